// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: Decode-side control, instruction-memory port and IF/ID outputs.
// master = fetch stage, slave = the surrounding pipeline and memory.
interface fetch_stage_if #(
   parameter int N = 32
);
   logic         Stall;
   logic         BranchTaken;
   logic [N-1:0] BranchTarget;
   logic         IMemReq;
   logic [N-1:0] IMemAddr;
   logic         IMemValid;
   logic [N-1:0] IMemData;
   logic [N-1:0] InstOut;
   logic [N-1:0] PCOut;
   logic         ValidOut;

   modport master (
      input  Stall, BranchTaken, BranchTarget, IMemValid, IMemData,
      output IMemReq, IMemAddr, InstOut, PCOut, ValidOut
   );

   modport slave (
      output Stall, BranchTaken, BranchTarget, IMemValid, IMemData,
      input  IMemReq, IMemAddr, InstOut, PCOut, ValidOut
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-aligned sequential fetch with a one-entry skid
// buffer for Decode stalls and redirect handling that drains an in-flight request.
module fetch_stage #(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   fetch_stage_if.master     bus,
   output logic [1:0]        dbg_state
);
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] out_addr_q, out_addr_d;
   logic [N-1:0] buf_q, buf_d;
   logic [N-1:0] buf_pc_q, buf_pc_d;
   logic [N-1:0] inst_q, inst_d;
   logic [N-1:0] pc_out_q, pc_out_d;
   logic         valid_q, valid_d;

   logic         imem_req;
   logic         accept;
   logic [N-1:0] target;

   // Memory address must hold while a request is outstanding; DRAIN replays the
   // address captured when the redirect arrived, not the new PC.
   assign imem_req     = (state_q != S_HOLD);
   assign bus.IMemReq  = imem_req;
   assign bus.IMemAddr = (state_q == S_DRAIN) ? out_addr_q : pc_q;
   assign accept       = imem_req & bus.IMemValid;
   assign target       = bus.BranchTarget & ~{{(N-2){1'b0}}, 2'b11};

   assign bus.InstOut  = inst_q;
   assign bus.PCOut    = pc_out_q;
   assign bus.ValidOut = valid_q;
   assign dbg_state    = state_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      out_addr_d = out_addr_q;
      buf_d      = buf_q;
      buf_pc_d   = buf_pc_q;
      inst_d     = inst_q;
      pc_out_d   = pc_out_q;
      valid_d    = valid_q;

      if (bus.BranchTaken) begin
         pc_d    = target;
         valid_d = 1'b0;
         inst_d  = '0;
      end

      case (state_q)
         S_FETCH: begin
            out_addr_d = pc_q;
            if (bus.BranchTaken) begin
               state_d = accept ? S_FETCH : S_DRAIN;
            end else if (accept) begin
               pc_d = pc_q + N'(4);
               if (bus.Stall) begin
                  buf_d    = bus.IMemData;
                  buf_pc_d = pc_q;
                  state_d  = S_HOLD;
               end else begin
                  inst_d   = bus.IMemData;
                  pc_out_d = pc_q;
                  valid_d  = 1'b1;
               end
            end else if (!bus.Stall) begin
               valid_d = 1'b0;
               inst_d  = '0;
            end
         end
         S_HOLD: begin
            if (bus.BranchTaken) begin
               state_d = S_FETCH;
            end else if (!bus.Stall) begin
               inst_d   = buf_q;
               pc_out_d = buf_pc_q;
               valid_d  = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_DRAIN: begin
            // A further redirect only retargets PC; the old request still drains.
            if (!bus.BranchTaken && accept) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         out_addr_q <= '0;
         buf_q      <= '0;
         buf_pc_q   <= '0;
         inst_q     <= '0;
         pc_out_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_addr_q <= out_addr_d;
         buf_q      <= buf_d;
         buf_pc_q   <= buf_pc_d;
         inst_q     <= inst_d;
         pc_out_q   <= pc_out_d;
         valid_q    <= valid_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  dbg_state;
   int          total = 0;
   int          bad   = 0;

   fetch_stage_if #(.N(32)) bus ();

   fetch_stage #(.N(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign bus.IMemData = mem_word(bus.IMemAddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed { logic [31:0] pc; logic [31:0] data; } skid_t;
   skid_t       skid[$];
   logic [31:0] m_pc = '0, m_disc_addr = '0, m_inst = '0, m_pcout = '0;
   logic        m_valid = 1'b0, m_disc = 1'b0;

   function automatic logic        m_req();  return skid.size() == 0; endfunction
   function automatic logic [31:0] m_addr(); return m_disc ? m_disc_addr : m_pc; endfunction

   initial forever begin
      logic acc;
      skid_t e;
      @(posedge clk or negedge rst);
      if (!rst) begin
         skid.delete();
         m_pc = '0; m_disc_addr = '0; m_inst = '0; m_pcout = '0;
         m_valid = 1'b0; m_disc = 1'b0;
      end else begin
         acc = m_req() && bus.IMemValid;
         if (bus.BranchTaken) begin
            if (!m_disc && skid.size() == 0 && !acc) begin
               m_disc = 1'b1;
               m_disc_addr = m_pc;
            end
            skid.delete();
            m_pc = bus.BranchTarget & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_inst = '0;
         end else if (m_disc) begin
            if (acc) m_disc = 1'b0;
         end else if (skid.size() != 0) begin
            if (!bus.Stall) begin
               e = skid.pop_front();
               m_inst = e.data; m_pcout = e.pc; m_valid = 1'b1;
            end
         end else if (acc) begin
            if (bus.Stall) skid.push_back({m_pc, mem_word(m_pc)});
            else begin
               m_inst = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
         end else if (!bus.Stall) begin
            m_valid = 1'b0; m_inst = '0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic        have_prev = 1'b0, prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;

   always @(negedge clk) begin
      if (rst) begin
         check("imem_req",  {31'd0, bus.IMemReq},  {31'd0, m_req()});
         check("imem_addr", bus.IMemAddr, m_addr());
         check("inst_out",  bus.InstOut,  m_inst);
         check("pc_out",    bus.PCOut,    m_pcout);
         check("valid_out", {31'd0, bus.ValidOut}, {31'd0, m_valid});
         if (have_prev && prev_hold) check("addr_stable", bus.IMemAddr, prev_addr);
         have_prev = 1'b1;
         prev_hold = bus.IMemReq && !bus.IMemValid;
         prev_addr = bus.IMemAddr;
      end else begin
         have_prev = 1'b0;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input logic stall, input logic br, input logic [31:0] tgt, input logic valid);
      bus.Stall = stall;
      bus.BranchTaken = br;
      bus.BranchTarget = tgt;
      bus.IMemValid = valid;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                             input logic valid, input logic req, input logic [31:0] addr);
      check({tag, ".inst"},  bus.InstOut, inst);
      check({tag, ".pc"},    bus.PCOut, pc);
      check({tag, ".valid"}, {31'd0, bus.ValidOut}, {31'd0, valid});
      check({tag, ".req"},   {31'd0, bus.IMemReq}, {31'd0, req});
      check({tag, ".addr"},  bus.IMemAddr, addr);
   endtask

   initial begin
      bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0; bus.IMemValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      rst = 1'b1;
      expect_out("first_req", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

      // zero-wait sequential fetch
      cyc(0, 0, 0, 1);
      expect_out("seq0", 32'hC0DE_0000, 32'h0, 1'b1, 1'b1, 32'h4);
      repeat (3) cyc(0, 0, 0, 1);
      expect_out("seq3", 32'hC0DE_000C, 32'hC, 1'b1, 1'b1, 32'h10);

      // two wait cycles at 0x10
      cyc(0, 0, 0, 0);
      expect_out("wait1", 32'h0, 32'hC, 1'b0, 1'b1, 32'h10);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      expect_out("wait_done", 32'hC0DE_0010, 32'h10, 1'b1, 1'b1, 32'h14);

      // stall coincident with accept at 0x20
      repeat (3) cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      expect_out("hold", 32'hC0DE_001C, 32'h1C, 1'b1, 1'b0, 32'h24);
      cyc(1, 0, 0, 0);
      check("hold2.pc", bus.PCOut, 32'h1C);
      cyc(0, 0, 0, 0);
      expect_out("unhold", 32'hC0DE_0020, 32'h20, 1'b1, 1'b1, 32'h24);
      cyc(0, 0, 0, 1);
      check("after_hold.pc", bus.PCOut, 32'h24);

      // redirect to 0x100 while waiting at 0x40
      repeat (6) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 32'h100, 0);
      expect_out("drain", 32'h0, 32'h3C, 1'b0, 1'b1, 32'h40);
      cyc(0, 0, 0, 0);
      check("drain2.addr", bus.IMemAddr, 32'h40);
      cyc(0, 0, 0, 1);
      expect_out("drained", 32'h0, 32'h3C, 1'b0, 1'b1, 32'h100);
      cyc(0, 0, 0, 1);
      expect_out("tgt100", 32'hC0DE_0100, 32'h100, 1'b1, 1'b1, 32'h104);

      // redirect with stall while holding; low target bits ignored
      cyc(1, 0, 0, 1);
      check("hold104.req", {31'd0, bus.IMemReq}, 32'd0);
      cyc(1, 1, 32'h102, 0);
      expect_out("br_hold", 32'h0, 32'h100, 1'b0, 1'b1, 32'h100);
      cyc(0, 0, 0, 1);
      expect_out("br_hold_fetch", 32'hC0DE_0100, 32'h100, 1'b1, 1'b1, 32'h104);

      // redirect on accept, then PC wrap
      cyc(0, 1, 32'hFFFF_FFFC, 1);
      expect_out("br_acc", 32'h0, 32'h100, 1'b0, 1'b1, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 1);
      expect_out("wrap", 32'h3F21_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0);

      // back-to-back redirects while draining
      cyc(0, 1, 32'h300, 0);
      cyc(0, 1, 32'h400, 0);
      check("drain_twice.addr", bus.IMemAddr, 32'h0);
      cyc(0, 0, 0, 1);
      check("newest_tgt.addr", bus.IMemAddr, 32'h400);
      cyc(0, 0, 0, 1);
      expect_out("tgt400", 32'hC0DE_0400, 32'h400, 1'b1, 1'b1, 32'h404);

      // async reset mid-DRAIN
      cyc(0, 1, 32'h500, 0);
      check("pre_rst.addr", bus.IMemAddr, 32'h404);
      #2 rst = 1'b0;
      #1;
      expect_out("async_rst", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      check("async_rst.state", {30'd0, dbg_state}, 32'd0);
      bus.BranchTaken = 1'b0; bus.IMemValid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      expect_out("post_rst", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      expect_out("post_rst_seq", 32'hC0DE_0004, 32'h4, 1'b1, 1'b1, 32'h8);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 32: instruction and address width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 Stall  in  1  downstream Decode cannot accept; hold IF/ID outputs.
REQ-005 BranchTaken  in  1  redirect fetch to BranchTarget.
REQ-006 BranchTarget  in  N  redirect address; bits [1:0] ignored and treated as 0.
REQ-007 IMemReq  out  1  instruction memory request.
REQ-008 IMemAddr  out  N  instruction memory address; word aligned.
REQ-009 IMemValid  in  1  memory response valid; may assert in the same cycle as IMemReq (zero wait).
REQ-010 IMemData  in  N  instruction word, sampled only when IMemReq=1 and IMemValid=1.
REQ-011 InstOut  out  N  IF/ID instruction register, consumed by Decode as inst.
REQ-012 PCOut  out  N  fetch address of InstOut, consumed by Decode as PC.
REQ-013 ValidOut  out  1  InstOut/PCOut hold a real instruction.

Function
REQ-014 Accept = IMemReq & IMemValid; the memory protocol requires IMemAddr to stay stable from IMemReq rise until Accept.
REQ-015 FSM states: FETCH, HOLD, DRAIN.
REQ-016 Internal registers: PC (next fetch address), OutAddr (address of the outstanding request), Buf/BufPC (skid buffer).
REQ-017 FETCH: IMemReq=1, IMemAddr=PC.
REQ-018 FETCH, Accept, Stall=0: on the edge, InstOut<=IMemData, PCOut<=PC, ValidOut<=1, PC<=PC+4; latency from Accept to outputs is 1 edge.
REQ-019 FETCH, Accept, Stall=1: Buf<=IMemData, BufPC<=PC, PC<=PC+4, go to HOLD; outputs unchanged.
REQ-020 FETCH, no Accept, Stall=0: ValidOut<=0 and InstOut<=0 (bubble); PCOut unchanged.
REQ-021 Any state, Stall=1, BranchTaken=0: InstOut, PCOut and ValidOut unchanged.
REQ-022 HOLD: IMemReq=0. When Stall=0: InstOut<=Buf, PCOut<=BufPC, ValidOut<=1, go to FETCH.
REQ-023 DRAIN: IMemReq=1 and IMemAddr=OutAddr. The response on Accept is discarded, then go to FETCH.
REQ-024 BranchTaken=1 has priority over Stall in all states; Stall does not delay a redirect.
REQ-025 On BranchTaken: PC<=BranchTarget, ValidOut<=0, InstOut<=0, Buf discarded.
REQ-026 BranchTaken, next state:
- from FETCH without Accept: DRAIN (the request is outstanding and OutAddr is kept);
- from FETCH with Accept: FETCH (the data is discarded);
- from HOLD: FETCH;
- from DRAIN: DRAIN (PC is updated to the newest target).
REQ-027 PC+4 wraps modulo 2^N with no flag.
REQ-028 The first request to BranchTarget is issued in the cycle after redirect, or after the DRAIN Accept.

Reset
REQ-029 While rst=0, and immediately on assertion:
- PC=0, OutAddr=0, Buf=0, BufPC=0;
- InstOut=0, PCOut=0, ValidOut=0;
- state=FETCH.
REQ-030 Reset mid-request (FETCH, DRAIN or HOLD) abandons the request with no discard tracking; memory is reset in the same domain.
REQ-031 After rst deasserts, IMemReq=1 with IMemAddr=0 in the first cycle.

Verification
REQ-032 Zero-wait memory, Stall=0: addresses 0,4,8,...; InstOut/PCOut follow one edge later; ValidOut=1 from the second edge.
REQ-033 Two wait cycles at PC=0x10: IMemAddr holds 0x10 for 3 cycles, ValidOut=0 during the waits, then InstOut=data, PCOut=0x10.
REQ-034 Stall=1 coincident with Accept at 0x20: IMemReq=0 while stalled, outputs keep the prior instruction; on Stall=0, PCOut=0x20, then fetch 0x24.
REQ-035 BranchTaken to 0x100 during a wait at 0x40: IMemAddr stays 0x40 until Valid, that data is never on InstOut, next request is 0x100.
REQ-036 BranchTaken with Stall=1 in HOLD: Buf is dropped, ValidOut=0, next IMemAddr=0x100.
REQ-037 rst low mid-DRAIN: all outputs 0 asynchronously; after release the first IMemAddr=0.
